// File: rtl/alu_result_gen_if.sv
// Handshake and data bundle between the EXE adder back-end and the MEM stage.
interface alu_result_gen_if #(
    parameter int BITS = 32
);
    logic            FLUSH;
    logic            IN_VALID;
    logic            IN_READY;
    logic [BITS-1:0] SUM;
    logic            CARRY;
    logic            A_MSB;
    logic            B_MSB;
    logic [1:0]      OPSEL;
    logic            NEG_RES;
    logic            OUT_VALID;
    logic            OUT_READY;
    logic [BITS-1:0] RESULT;
    logic            FLAG_Z;
    logic            FLAG_N;
    logic            FLAG_C;
    logic            FLAG_V;

    // Pipeline side: drives the adder result and MEM-side ready, observes outputs.
    modport master (
        output FLUSH, IN_VALID, SUM, CARRY, A_MSB, B_MSB, OPSEL, NEG_RES, OUT_READY,
        input  IN_READY, OUT_VALID, RESULT, FLAG_Z, FLAG_N, FLAG_C, FLAG_V
    );

    // Result generator side.
    modport slave (
        input  FLUSH, IN_VALID, SUM, CARRY, A_MSB, B_MSB, OPSEL, NEG_RES, OUT_READY,
        output IN_READY, OUT_VALID, RESULT, FLAG_Z, FLAG_N, FLAG_C, FLAG_V
    );
endinterface

// File: rtl/alu_result_gen.sv
// EXE-stage result back-end: optional result negation, Z/N/C/V flag
// generation and a 2-entry valid/ready skid buffer towards MEM.
module alu_result_gen #(
    parameter int BITS = 32
) (
    input logic              CLK,
    input logic              RST_N,
    alu_result_gen_if.slave  bus
);
    // Entry layout: {result, Z, N, C, V}
    localparam int EW = BITS + 4;

    logic [BITS-1:0] w_result;
    logic            w_z;
    logic            w_n;
    logic            w_c;
    logic            w_v;
    logic [EW-1:0]   w_entry;
    logic            w_accept;
    logic            w_xfer;

    logic [EW-1:0]   r_main;
    logic [EW-1:0]   r_skid;
    logic            r_main_vld;
    logic            r_skid_vld;

    // Result recovery and flag computation on the incoming adder output.
    always_comb begin
        w_result = bus.NEG_RES ? (~bus.SUM + BITS'(1)) : bus.SUM;
        w_z      = (w_result == '0);
        w_n      = w_result[BITS-1];
        // Inverted or zeroed B has no meaningful carry, so C is forced low.
        w_c      = bus.OPSEL[1] ? 1'b0 : bus.CARRY;
        // Overflow judged on the raw sum so negation cannot mask it.
        w_v      = (bus.A_MSB == bus.B_MSB) && (bus.SUM[BITS-1] != bus.A_MSB);
        w_entry  = {w_result, w_z, w_n, w_c, w_v};
    end

    // Skid register is only ever occupied while main is, so it alone marks "full".
    assign w_accept = bus.IN_VALID && !r_skid_vld;
    assign w_xfer   = r_main_vld && bus.OUT_READY;

    // Skid buffer occupancy and data movement; FLUSH discards everything.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_main     <= '0;
            r_skid     <= '0;
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (bus.FLUSH) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (!r_main_vld) begin
            if (w_accept) begin
                r_main     <= w_entry;
                r_main_vld <= 1'b1;
            end
        end else if (!r_skid_vld) begin
            if (w_xfer && w_accept) begin
                r_main <= w_entry;
            end else if (w_xfer) begin
                r_main_vld <= 1'b0;
            end else if (w_accept) begin
                r_skid     <= w_entry;
                r_skid_vld <= 1'b1;
            end
        end else if (w_xfer) begin
            r_main     <= r_skid;
            r_skid_vld <= 1'b0;
        end
    end

    // Outputs come straight from registered state only.
    always_comb begin
        bus.IN_READY  = !r_skid_vld;
        bus.OUT_VALID = r_main_vld;
        bus.RESULT    = r_main[EW-1:4];
        bus.FLAG_Z    = r_main[3];
        bus.FLAG_N    = r_main[2];
        bus.FLAG_C    = r_main[1];
        bus.FLAG_V    = r_main[0];
    end
endmodule

// File: tb/tb_alu_result_gen.sv
// Self-checking bench for alu_result_gen: directed scenarios followed by
// random traffic, compared against a queue-based reference model.
module tb_alu_result_gen;
    localparam int BITS = 32;

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
    } exp_t;

    logic CLK;
    logic RST_N;
    int   n_pass;
    int   n_total;
    int   n_fail;
    exp_t q[$];

    alu_result_gen_if #(.BITS(BITS)) bus ();

    alu_result_gen #(.BITS(BITS)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: arithmetic straight from the result/flag rules.
    function automatic exp_t model_of(input logic [31:0] sum, input logic carry,
                                      input logic a, input logic b,
                                      input logic [1:0] opsel, input logic neg);
        exp_t e;
        longint unsigned r;
        r   = neg ? ((64'h1_0000_0000 - {32'h0, sum}) % 64'h1_0000_0000) : {32'h0, sum};
        e.r = r[31:0];
        e.z = (r == 0);
        e.n = (r >= 64'h8000_0000);
        e.c = (opsel == 2'd0 || opsel == 2'd1) ? carry : 1'b0;
        e.v = (a == b) && ((sum >= 32'h8000_0000) != a);
        return e;
    endfunction

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs();
        check1("out_valid", bus.OUT_VALID, q.size() > 0);
        check1("in_ready", bus.IN_READY, q.size() < 2);
        if (q.size() > 0) begin
            check32("result", bus.RESULT, q[0].r);
            check1("flag_z", bus.FLAG_Z, q[0].z);
            check1("flag_n", bus.FLAG_N, q[0].n);
            check1("flag_c", bus.FLAG_C, q[0].c);
            check1("flag_v", bus.FLAG_V, q[0].v);
        end
    endtask

    task automatic set_in(input logic v, input logic [31:0] sum, input logic carry,
                          input logic a, input logic b, input logic [1:0] opsel,
                          input logic neg);
        bus.IN_VALID = v;
        bus.SUM      = sum;
        bus.CARRY    = carry;
        bus.A_MSB    = a;
        bus.B_MSB    = b;
        bus.OPSEL    = opsel;
        bus.NEG_RES  = neg;
    endtask

    // One clock: update the model with the inputs present at the edge, then check.
    task automatic step();
        bit acc;
        bit xfer;
        @(posedge CLK);
        acc  = bus.IN_VALID && (q.size() < 2);
        xfer = (q.size() > 0) && bus.OUT_READY;
        if (bus.FLUSH) begin
            q.delete();
        end else begin
            if (xfer) void'(q.pop_front());
            if (acc)  q.push_back(model_of(bus.SUM, bus.CARRY, bus.A_MSB, bus.B_MSB,
                                           bus.OPSEL, bus.NEG_RES));
        end
        @(negedge CLK);
        check_outs();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        n_fail  = 0;
        RST_N   = 1'b0;
        bus.FLUSH     = 1'b0;
        bus.OUT_READY = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

        // Reset state, during and after reset.
        repeat (2) @(negedge CLK);
        check1("rst_out_valid", bus.OUT_VALID, 1'b0);
        check32("rst_result", bus.RESULT, 32'h0);
        check1("rst_in_ready", bus.IN_READY, 1'b1);
        check1("rst_flags", bus.FLAG_Z | bus.FLAG_N | bus.FLAG_C | bus.FLAG_V, 1'b0);
        RST_N = 1'b1;
        step();

        // Simple pass-through, one-cycle latency.
        set_in(1'b1, 32'h5, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        step();
        check32("pass_result", bus.RESULT, 32'h5);
        check1("pass_valid", bus.OUT_VALID, 1'b1);

        // 3 - 5 with magnitude recovery.
        set_in(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1);
        step();
        check32("sub_result", bus.RESULT, 32'h2);
        check1("sub_v", bus.FLAG_V, 1'b0);

        // Signed overflow, raw and negated.
        set_in(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        step();
        check1("ovf_v", bus.FLAG_V, 1'b1);
        check1("ovf_n", bus.FLAG_N, 1'b1);
        set_in(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        step();
        check32("ovf_neg_result", bus.RESULT, 32'h8000_0000);
        check1("ovf_neg_v", bus.FLAG_V, 1'b1);

        // Zero negated stays zero; carry masked for inverted B.
        set_in(1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1);
        step();
        check1("zero_neg_z", bus.FLAG_Z, 1'b1);
        check1("inv_c", bus.FLAG_C, 1'b0);
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        step();

        // Stall: push 1, 2, 3 while MEM is not ready; 3 is held by the source.
        bus.OUT_READY = 1'b0;
        set_in(1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        step();
        set_in(1'b1, 32'h2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        step();
        check1("stall_full", bus.IN_READY, 1'b0);
        set_in(1'b1, 32'h3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        step();
        check32("stall_hold1", bus.RESULT, 32'h1);
        bus.OUT_READY = 1'b1;
        step();
        check32("drain2", bus.RESULT, 32'h2);
        step();
        check32("drain3", bus.RESULT, 32'h3);
        bus.IN_VALID = 1'b0;
        step();
        check1("drained", bus.OUT_VALID, 1'b0);

        // Flush with two buffered and a simultaneous push.
        bus.OUT_READY = 1'b0;
        set_in(1'b1, 32'hA, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        step();
        set_in(1'b1, 32'hB, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        step();
        bus.FLUSH = 1'b1;
        set_in(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        step();
        check1("flush_valid", bus.OUT_VALID, 1'b0);
        check1("flush_ready", bus.IN_READY, 1'b1);
        bus.FLUSH     = 1'b0;
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b1;
        repeat (2) step();

        // Asynchronous reset mid-stall with both entries full.
        bus.OUT_READY = 1'b0;
        set_in(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        step();
        set_in(1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        step();
        bus.IN_VALID = 1'b0;
        #2;
        RST_N = 1'b0;
        q.delete();
        #1;
        check1("async_rst_valid", bus.OUT_VALID, 1'b0);
        check32("async_rst_result", bus.RESULT, 32'h0);
        check1("async_rst_ready", bus.IN_READY, 1'b1);
        @(negedge CLK);
        RST_N = 1'b1;
        bus.OUT_READY = 1'b1;
        repeat (2) step();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus.IN_VALID  = ($urandom_range(0, 3) != 0);
            bus.OUT_READY = ($urandom_range(0, 2) != 0);
            bus.FLUSH     = ($urandom_range(0, 31) == 0);
            bus.SUM       = $urandom;
            case ($urandom_range(0, 9))
                0: bus.SUM = 32'h0;
                1: bus.SUM = 32'h8000_0000;
                2: bus.SUM = 32'hFFFF_FFFF;
                default: ;
            endcase
            bus.CARRY   = 1'($urandom_range(0, 1));
            bus.A_MSB   = 1'($urandom_range(0, 1));
            bus.B_MSB   = 1'($urandom_range(0, 1));
            bus.OPSEL   = 2'($urandom_range(0, 3));
            bus.NEG_RES = 1'($urandom_range(0, 1));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_result_gen.md
Name: alu_result_gen

Overview:
- EXE-stage result back-end, at the opposite end of the adder from the operand-input generator.
- Takes the raw adder sum and carry produced from conditioned operands.
- Optionally undoes a two's-complement conditioning on the result (magnitude/sign recovery).
- Computes Z/N/C/V flags and hands result plus flags to the MEM stage through a 2-entry valid/ready skid buffer, so EXE never loses a result when MEM stalls.

Parameters:
- BITS, 32, datapath width of SUM and RESULT.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- FLUSH  input  1  synchronous flush (mispredict); drops all buffered entries.
- IN_VALID  input  1  EXE presents a result this cycle.
- IN_READY  output  1  block can accept a result this cycle.
- SUM  input  BITS  raw adder output.
- CARRY  input  1  adder carry-out (bit BITS of the widened sum).
- A_MSB  input  1  MSB of the adder A operand after conditioning.
- B_MSB  input  1  MSB of the adder B operand after conditioning.
- OPSEL  input  2  operand-conditioning code used for B: 00 pass, 01 two's complement, 10 inverted, 11 zero.
- NEG_RES  input  1  negate the result (two's complement) before output.
- OUT_VALID  output  1  RESULT/flags valid.
- OUT_READY  input  1  MEM accepts the current output.
- RESULT  output  BITS  final result.
- FLAG_Z  output  1  zero flag.
- FLAG_N  output  1  negative flag.
- FLAG_C  output  1  carry flag.
- FLAG_V  output  1  signed overflow flag.

Behaviour:
- Reset (RST_N=0, asynchronous): both entries invalid; stored data and flags cleared to 0.
  - Outputs during and after reset: OUT_VALID=0, RESULT=0, all flags 0, IN_READY=1.
- Compute, combinational on the inputs; captured on accept:
  - R = NEG_RES ? (~SUM + 1) mod 2^BITS : SUM.
  - Z = (R == 0).
  - N = R[BITS-1].
  - C = CARRY when OPSEL is 00 or 01 (01: C=1 means no borrow); C = 0 when OPSEL is 10 or 11.
  - V = (A_MSB == B_MSB) && (SUM[BITS-1] != A_MSB). V is computed on the raw SUM and is not affected by NEG_RES.
- Storage:
  - Main register drives the outputs; skid register holds one overflow entry.
  - Occupancy count is 0..2.
- Handshake:
  - Accept when IN_VALID && IN_READY.
  - Transfer when OUT_VALID && OUT_READY.
  - IN_READY = (count != 2), derived from registered state only, never from OUT_READY.
  - Latency: a result accepted at edge k is visible on OUT_VALID/RESULT after edge k (1 cycle) when the main register is empty or transferring.
- Occupancy rules:
  - count 0, accept: goes to main.
  - count 1, accept, no transfer: goes to skid.
  - count 1, accept and transfer: new entry replaces main.
  - count 2, transfer: skid moves to main; skid becomes empty.
  - count 2: no accept possible (IN_READY=0).
- Ordering: strict FIFO; no entry is duplicated or dropped except by FLUSH.
- Outputs held stable while OUT_VALID=1 and OUT_READY=0.
- FLUSH=1 at an edge:
  - count becomes 0 and OUT_VALID becomes 0.
  - A simultaneous accept is discarded; FLUSH wins.
  - A simultaneous transfer is considered completed.
- Reset mid-stall: all entries lost immediately; no output pulse after release.
- Boundary: SUM=0 with NEG_RES=1 gives R=0 and Z=1. SUM=0x80000000 with NEG_RES=1 gives R=0x80000000 and N=1.

Test Plan:
- Reset, then IN_VALID with SUM=0x00000005, CARRY=0, OPSEL=00, OUT_READY=1 -> next cycle OUT_VALID=1, RESULT=5, Z=0, N=0, C=0, V=0.
- Subtract 3-5: SUM=0xFFFFFFFE, CARRY=0, OPSEL=01, A_MSB=0, B_MSB=1, NEG_RES=1 -> RESULT=2, Z=0, N=0, C=0, V=0.
- Overflow: SUM=0x80000000, A_MSB=0, B_MSB=0, OPSEL=00 -> V=1, N=1; with NEG_RES=1 -> RESULT=0x80000000, V=1.
- OUT_READY=0, push 1, 2, 3 on consecutive cycles -> IN_READY=0 after the 2nd accept, 3 held by the source; release OUT_READY -> outputs 1, 2, 3 in order, none lost.
- Two entries buffered, FLUSH=1 together with IN_VALID -> next cycle OUT_VALID=0, IN_READY=1, no entry ever emitted.
- Assert RST_N=0 mid-cycle with count=2 -> OUT_VALID and RESULT drop to 0 immediately, without waiting for CLK.
